fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC requests to instruction memory within a credit
// window, collects in-order responses, and presents them to decode in program order.
module fetch_queue #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    output logic                   imem_req_valid,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    input  logic                   out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] alloc_ptr_reg;
    logic [PW-1:0] fill_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] drop_cnt_reg;

    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]       filled_reg;

    logic [AW-1:0] alloc_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] rd_idx;
    logic [PW-1:0] occupancy;
    logic [PW-1:0] outstanding;
    logic [PW-1:0] flush_pending;
    logic [PW:0]   used;
    logic          credit;
    logic          req_valid_int;
    logic          req_fire;
    logic          rsp_fill;
    logic          rsp_drop;
    logic          head_valid;
    logic          pop;
    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] fill_hit;

    assign alloc_idx   = alloc_ptr_reg[AW-1:0];
    assign fill_idx    = fill_ptr_reg[AW-1:0];
    assign rd_idx      = rd_ptr_reg[AW-1:0];
    assign occupancy   = alloc_ptr_reg - rd_ptr_reg;
    assign outstanding = alloc_ptr_reg - fill_ptr_reg;

    // Stale in-flight responses still occupy a slot's worth of credit until they drain.
    assign used   = {1'b0, occupancy} + {1'b0, drop_cnt_reg};
    assign credit = (used < (PW+1)'(DEPTH));

    assign req_valid_int = rst && pc_valid && credit && !flush;
    assign req_fire      = req_valid_int && imem_req_ready;

    // Responses with nothing outstanding are protocol violations and are ignored.
    assign rsp_fill = imem_rsp_valid && !flush && (drop_cnt_reg == '0) && (outstanding != '0);
    assign rsp_drop = imem_rsp_valid && !flush && (drop_cnt_reg != '0);

    assign head_valid = filled_reg[rd_idx] && (rd_ptr_reg != fill_ptr_reg);
    assign pop        = head_valid && out_ready && !flush;

    assign flush_pending = drop_cnt_reg + outstanding;

    assign imem_req_valid = req_valid_int;
    assign imem_req_addr  = pc_in;
    assign pc_ready       = req_fire;
    assign out_valid      = rst && head_valid;
    assign out_pc         = rst ? pc_mem[rd_idx]    : '0;
    assign out_instr      = rst ? instr_mem[rd_idx] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_hit
            assign alloc_hit[gi] = req_fire && (alloc_idx == AW'(gi));
            assign fill_hit[gi]  = rsp_fill && (fill_idx == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[alloc_idx] <= pc_in;
        end
        if (rsp_fill) begin
            instr_mem[fill_idx] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled_reg <= '0;
        end else begin
            filled_reg <= (filled_reg & ~alloc_hit) | fill_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            drop_cnt_reg  <= '0;
        end else if (flush) begin
            // Everything not yet answered becomes a response to throw away.
            alloc_ptr_reg <= alloc_ptr_reg;
            fill_ptr_reg  <= alloc_ptr_reg;
            rd_ptr_reg    <= alloc_ptr_reg;
            if (imem_rsp_valid && (flush_pending != '0)) begin
                drop_cnt_reg <= flush_pending - PW'(1);
            end else begin
                drop_cnt_reg <= flush_pending;
            end
        end else begin
            if (req_fire) begin
                alloc_ptr_reg <= alloc_ptr_reg + PW'(1);
            end
            if (rsp_fill) begin
                fill_ptr_reg <= fill_ptr_reg + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt_reg <= drop_cnt_reg - PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for fetch/full behaviour plus
// hand-built sequences for flush, streaming wrap-around and mid-run reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    int n_cmp;
    int n_fail;

    fetch_queue #(.PC_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pv;
        logic [15:0] pc;
        logic        rr;
        logic        rsp;
        logic [31:0] data;
        logic        fl;
        logic        ordy;
        logic        e_rv;
        logic        e_pr;
        logic        e_ov;
        logic [15:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(logic pv, logic [15:0] pc, logic rr, logic rsp,
                                logic [31:0] data, logic fl, logic ordy,
                                logic e_rv, logic e_pr, logic e_ov,
                                logic [15:0] e_pc, logic [31:0] e_instr);
        vec_t v;
        v.pv = pv; v.pc = pc; v.rr = rr; v.rsp = rsp; v.data = data; v.fl = fl;
        v.ordy = ordy; v.e_rv = e_rv; v.e_pr = e_pr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare at the falling edge, then cross the rising edge.
    task automatic apply(input vec_t v, input string tag);
        pc_valid       = v.pv;
        pc_in          = v.pc;
        imem_req_ready = v.rr;
        imem_rsp_valid = v.rsp;
        imem_rsp_data  = v.data;
        flush          = v.fl;
        out_ready      = v.ordy;
        @(negedge clk);
        chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'(v.e_rv));
        chk({tag, ".pc_ready"},  64'(pc_ready),       64'(v.e_pr));
        if (v.e_rv) chk({tag, ".req_addr"}, 64'(imem_req_addr), 64'(v.pc));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.e_ov));
        if (v.e_ov) begin
            chk({tag, ".out_pc"},    64'(out_pc),    64'(v.e_pc));
            chk({tag, ".out_instr"}, 64'(out_instr), 64'(v.e_instr));
        end
        $display("cycle %s: pv=%0d pc=%h rsp=%0d fl=%0d rdy=%0d -> rv=%0d pr=%0d ov=%0d opc=%h oi=%h",
                 tag, v.pv, v.pc, v.rsp, v.fl, v.ordy, imem_req_valid, pc_ready,
                 out_valid, out_pc, out_instr);
        @(posedge clk);
        #1;
    endtask

    localparam int NSTREAM = 26;

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Basic fetch, then fill to capacity with decode stalled, then drain.
        vecs[0]  = mk(1, 16'h0000, 1, 0, 32'h0,        0, 0, 1, 1, 0, 16'h0,    32'h0);
        vecs[1]  = mk(0, 16'h0000, 1, 1, 32'h00500093, 0, 0, 0, 0, 0, 16'h0,    32'h0);
        vecs[2]  = mk(0, 16'h0000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 16'h0000, 32'h00500093);
        vecs[3]  = mk(0, 16'h0000, 1, 0, 32'h0,        0, 0, 0, 0, 0, 16'h0,    32'h0);
        vecs[4]  = mk(1, 16'h0000, 1, 0, 32'h0,        0, 0, 1, 1, 0, 16'h0,    32'h0);
        vecs[5]  = mk(1, 16'h0004, 1, 1, 32'hA0,       0, 0, 1, 1, 0, 16'h0,    32'h0);
        vecs[6]  = mk(1, 16'h0008, 1, 1, 32'hA1,       0, 0, 1, 1, 1, 16'h0000, 32'hA0);
        vecs[7]  = mk(1, 16'h000C, 1, 1, 32'hA2,       0, 0, 1, 1, 1, 16'h0000, 32'hA0);
        vecs[8]  = mk(1, 16'h0010, 1, 1, 32'hA3,       0, 0, 0, 0, 1, 16'h0000, 32'hA0);
        vecs[9]  = mk(1, 16'h0010, 1, 0, 32'h0,        0, 1, 0, 0, 1, 16'h0000, 32'hA0);
        vecs[10] = mk(1, 16'h0010, 1, 0, 32'h0,        0, 0, 1, 1, 1, 16'h0004, 32'hA1);
        vecs[11] = mk(0, 16'h0000, 1, 1, 32'hA4,       0, 1, 0, 0, 1, 16'h0004, 32'hA1);
        vecs[12] = mk(0, 16'h0000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 16'h0008, 32'hA2);
        vecs[13] = mk(0, 16'h0000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 16'h000C, 32'hA3);
        vecs[14] = mk(0, 16'h0000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 16'h0010, 32'hA4);
        vecs[15] = mk(1, 16'h0020, 0, 0, 32'h0,        0, 1, 1, 0, 0, 16'h0,    32'h0);

        // Reset asserted from time zero with busy inputs: outputs must be quiet.
        rst = 1'b0;
        pc_valid = 1'b1; pc_in = 16'h1234; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("reset.req_valid", 64'(imem_req_valid), 64'd0);
        chk("reset.pc_ready",  64'(pc_ready),       64'd0);
        chk("reset.out_valid", 64'(out_valid),      64'd0);
        chk("reset.out_pc",    64'(out_pc),         64'd0);
        chk("reset.out_instr", 64'(out_instr),      64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], $sformatf("tbl%0d", i));
        end

        // Flush with two requests in flight: both answers dropped, third lands.
        apply(mk(1, 16'h0040, 1, 0, 32'h0,       0, 0, 1, 1, 0, 16'h0,    32'h0),       "fl2a");
        apply(mk(1, 16'h0044, 1, 0, 32'h0,       0, 0, 1, 1, 0, 16'h0,    32'h0),       "fl2b");
        apply(mk(1, 16'h0048, 1, 0, 32'h0,       1, 1, 0, 0, 0, 16'h0,    32'h0),       "fl2c");
        apply(mk(1, 16'h0100, 1, 0, 32'h0,       0, 1, 1, 1, 0, 16'h0,    32'h0),       "fl2d");
        apply(mk(0, 16'h0000, 1, 1, 32'hDEAD1,   0, 1, 0, 0, 0, 16'h0,    32'h0),       "fl2e");
        apply(mk(0, 16'h0000, 1, 1, 32'hDEAD2,   0, 1, 0, 0, 0, 16'h0,    32'h0),       "fl2f");
        apply(mk(0, 16'h0000, 1, 1, 32'hC0FFEE,  0, 1, 0, 0, 0, 16'h0,    32'h0),       "fl2g");
        apply(mk(0, 16'h0000, 1, 0, 32'h0,       0, 1, 0, 0, 1, 16'h0100, 32'hC0FFEE),  "fl2h");
        apply(mk(0, 16'h0000, 1, 0, 32'h0,       0, 1, 0, 0, 0, 16'h0,    32'h0),       "fl2i");

        // Flush coinciding with a response and a would-be pop: one stale answer remains.
        apply(mk(1, 16'h0200, 1, 0, 32'h0,       0, 0, 1, 1, 0, 16'h0,    32'h0),       "flca");
        apply(mk(1, 16'h0204, 1, 0, 32'h0,       0, 0, 1, 1, 0, 16'h0,    32'h0),       "flcb");
        apply(mk(1, 16'h0208, 1, 1, 32'hB0,      0, 0, 1, 1, 0, 16'h0,    32'h0),       "flcc");
        apply(mk(0, 16'h0000, 1, 1, 32'hB1,      1, 1, 0, 0, 1, 16'h0200, 32'hB0),      "flcd");
        apply(mk(1, 16'h0300, 1, 0, 32'h0,       0, 1, 1, 1, 0, 16'h0,    32'h0),       "flce");
        apply(mk(0, 16'h0000, 1, 1, 32'h5A1E,    0, 1, 0, 0, 0, 16'h0,    32'h0),       "flcf");
        apply(mk(0, 16'h0000, 1, 1, 32'hD300,    0, 1, 0, 0, 0, 16'h0,    32'h0),       "flcg");
        apply(mk(0, 16'h0000, 1, 0, 32'h0,       0, 1, 0, 0, 1, 16'h0300, 32'hD300),    "flch");

        // Streaming with a one-cycle memory: one instruction per cycle across several wraps.
        for (int t = 0; t <= NSTREAM + 1; t++) begin
            logic        pv_t, rsp_t, ov_t;
            logic [15:0] pc_t, epc_t;
            logic [31:0] d_t, ei_t;
            pv_t  = (t < NSTREAM);
            pc_t  = 16'h1000 + 16'(4 * t);
            rsp_t = (t >= 1) && (t <= NSTREAM);
            d_t   = 32'hA000_0000 + 32'(t - 1);
            ov_t  = (t >= 2);
            epc_t = 16'h1000 + 16'(4 * (t - 2));
            ei_t  = 32'hA000_0000 + 32'(t - 2);
            apply(mk(pv_t, pc_t, 1, rsp_t, d_t, 0, 1, pv_t, pv_t, ov_t, epc_t, ei_t),
                  $sformatf("strm%0d", t));
        end

        // Reset in the middle of operation with three entries busy.
        apply(mk(1, 16'h0600, 1, 0, 32'h0,  0, 0, 1, 1, 0, 16'h0,    32'h0),  "rsta");
        apply(mk(1, 16'h0604, 1, 1, 32'hE0, 0, 0, 1, 1, 0, 16'h0,    32'h0),  "rstb");
        apply(mk(1, 16'h0608, 1, 0, 32'h0,  0, 0, 1, 1, 1, 16'h0600, 32'hE0), "rstc");
        pc_valid = 1'b1; pc_in = 16'h060C; out_ready = 1'b1; imem_rsp_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst.req_valid", 64'(imem_req_valid), 64'd0);
        chk("midrst.pc_ready",  64'(pc_ready),       64'd0);
        chk("midrst.out_valid", 64'(out_valid),      64'd0);
        chk("midrst.out_pc",    64'(out_pc),         64'd0);
        chk("midrst.out_instr", 64'(out_instr),      64'd0);
        $display("cycle midrst: rv=%0d pr=%0d ov=%0d opc=%h oi=%h",
                 imem_req_valid, pc_ready, out_valid, out_pc, out_instr);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk(0, 16'h0000, 1, 1, 32'hE1, 0, 1, 0, 0, 0, 16'h0,    32'h0),  "late1");
        apply(mk(0, 16'h0000, 1, 1, 32'hE2, 0, 1, 0, 0, 0, 16'h0,    32'h0),  "late2");
        apply(mk(1, 16'h0700, 1, 0, 32'h0,  0, 1, 1, 1, 0, 16'h0,    32'h0),  "post1");
        apply(mk(0, 16'h0000, 1, 1, 32'hF0, 0, 1, 0, 0, 0, 16'h0,    32'h0),  "post2");
        apply(mk(0, 16'h0000, 1, 0, 32'h0,  0, 1, 0, 0, 1, 16'h0700, 32'hF0), "post3");
        apply(mk(0, 16'h0000, 1, 0, 32'h0,  0, 1, 0, 0, 0, 16'h0,    32'h0),  "post4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
